regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between two requesters. Requester A is pipeline writeback and has priority. Requester B is a load/fill return path and is buffered in a small FIFO. The block drives the write-port controls (WriteReg, DstReg, DstData) that feed the 4-to-16 write decoder and register array, one registered write per cycle. A starvation counter guarantees forward progress for B.

---
 rtl/regfile_write_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: A (writeback) has priority, B is FIFO-buffered with starvation forcing.
// Optional macro REGWR_PENDING_MASK_EN adds pending_mask, the set of registers targeted by queued B entries.
module regfile_write_arbiter #(
    parameter int unsigned B_DEPTH      = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [3:0]                a_reg,
    input  logic [15:0]               a_data,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [3:0]                b_reg,
    input  logic [15:0]               b_data,
    output logic                      WriteReg,
    output logic [3:0]                DstReg,
    output logic [15:0]               DstData,
    output logic [$clog2(B_DEPTH):0]  b_count,
    output logic                      forced_b
`ifdef REGWR_PENDING_MASK_EN
    ,
    output logic [15:0]               pending_mask
`endif
);

    localparam int unsigned PTR_W = $clog2(B_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [3:0]       fifo_reg_q  [B_DEPTH];
    logic [15:0]      fifo_data_q [B_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       starve_q, starve_d;
    logic             write_q, write_d;
    logic [3:0]       dst_reg_q, dst_reg_d;
    logic [15:0]      dst_data_q, dst_data_d;
    logic             forced_q, forced_d;

    logic empty, full, force_b, grant_a, grant_b, push, pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNT_W'(B_DEPTH));
        force_b = !empty && (starve_q == 4'(STARVE_LIMIT));
        grant_a = !force_b && a_valid;
        grant_b = !empty && (force_b || !a_valid);
        push    = b_valid && !full;
        pop     = grant_b;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        // Saturating: once at the limit it stays there until B is served.
        if (empty || grant_b)
            starve_d = '0;
        else if (grant_a && (starve_q != 4'(STARVE_LIMIT)))
            starve_d = starve_q + 4'd1;
        else
            starve_d = starve_q;

        write_d    = 1'b0;
        dst_reg_d  = dst_reg_q;
        dst_data_d = dst_data_q;
        if (grant_a) begin
            write_d    = (a_reg != 4'd0);
            dst_reg_d  = a_reg;
            dst_data_d = a_data;
        end else if (grant_b) begin
            write_d    = (fifo_reg_q[rd_ptr_q] != 4'd0);
            dst_reg_d  = fifo_reg_q[rd_ptr_q];
            dst_data_d = fifo_data_q[rd_ptr_q];
        end

        forced_d = force_b;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg_q[wr_ptr_q]  <= b_reg;
            fifo_data_q[wr_ptr_q] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            write_q    <= 1'b0;
            dst_reg_q  <= '0;
            dst_data_q <= '0;
            forced_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            write_q    <= write_d;
            dst_reg_q  <= dst_reg_d;
            dst_data_q <= dst_data_d;
            forced_q   <= forced_d;
        end
    end

    assign a_ready  = !force_b;
    assign b_ready  = !full;
    assign b_count  = count_q;
    assign WriteReg = write_q;
    assign DstReg   = dst_reg_q;
    assign DstData  = dst_data_q;
    assign forced_b = forced_q;

`ifdef REGWR_PENDING_MASK_EN
    logic [PTR_W-1:0] mask_off;

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        pending_mask = '0;
        mask_off     = '0;
        for (int unsigned i = 0; i < B_DEPTH; i++) begin
            mask_off = PTR_W'(i) - rd_ptr_q;
            if (CNT_W'(mask_off) < count_q)
                pending_mask[fifo_reg_q[i]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (default B_DEPTH=2, STARVE_LIMIT=3).
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready;
    logic [3:0]  a_reg;
    logic [15:0] a_data;
    logic        b_valid, b_ready;
    logic [3:0]  b_reg;
    logic [15:0] b_data;
    logic        WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic [1:0]  b_count;
    logic        forced_b;
`ifdef REGWR_PENDING_MASK_EN
    logic [15:0] pending_mask;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.B_DEPTH(2), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
        .b_count(b_count), .forced_b(forced_b)
`ifdef REGWR_PENDING_MASK_EN
        , .pending_mask(pending_mask)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;
        tick; tick;
        tests++; if (WriteReg !== 1'b0) begin fails++; $display("FAIL rst_wr: got %0b want 0", WriteReg); end
        tests++; if (DstReg !== 4'd0) begin fails++; $display("FAIL rst_dstreg: got %0d want 0", DstReg); end
        tests++; if (DstData !== 16'h0) begin fails++; $display("FAIL rst_dstdata: got %h want 0000", DstData); end
        tests++; if (b_count !== 2'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", b_count); end
        tests++; if (forced_b !== 1'b0) begin fails++; $display("FAIL rst_forced: got %0b want 0", forced_b); end
        rst = 1'b0;
        tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL rst_bready: got %0b want 1", b_ready); end
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL rst_aready: got %0b want 1", a_ready); end
        tick;
        tests++; if (WriteReg !== 1'b0) begin fails++; $display("FAIL idle_wr: got %0b want 0", WriteReg); end
    endtask

    task automatic test_a_only;
        a_valid = 1'b1; a_reg = 4'd5; a_data = 16'hBEEF;
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL a_ready: got %0b want 1", a_ready); end
        tick;
        a_valid = 1'b0;
        tests++; if (WriteReg !== 1'b1) begin fails++; $display("FAIL a_wr: got %0b want 1", WriteReg); end
        tests++; if (DstReg !== 4'd5) begin fails++; $display("FAIL a_dstreg: got %0d want 5", DstReg); end
        tests++; if (DstData !== 16'hBEEF) begin fails++; $display("FAIL a_dstdata: got %h want beef", DstData); end
        tick;
        tests++; if (WriteReg !== 1'b0) begin fails++; $display("FAIL a_idle_wr: got %0b want 0", WriteReg); end
        tests++; if (DstData !== 16'hBEEF) begin fails++; $display("FAIL a_hold_data: got %h want beef", DstData); end
    endtask

    task automatic test_starvation;
        a_valid = 1'b1; a_reg = 4'd1; a_data = 16'h0001;
        b_valid = 1'b1; b_reg = 4'd7; b_data = 16'h1234;
        tick;
        b_valid = 1'b0;
        tests++; if (b_count !== 2'd1) begin fails++; $display("FAIL st_count: got %0d want 1", b_count); end
        for (int k = 0; k < 3; k++) begin
            a_data = 16'(k + 2);
            tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL st_aready%0d: got %0b want 1", k, a_ready); end
            tick;
            tests++; if (DstData !== 16'(k + 2) || DstReg !== 4'd1) begin
                fails++; $display("FAIL st_agrant%0d: got r%0d %h want r1 %h", k, DstReg, DstData, 16'(k + 2)); end
            tests++; if (forced_b !== 1'b0) begin fails++; $display("FAIL st_noforce%0d: got %0b want 0", k, forced_b); end
        end
        a_data = 16'h0099;
        tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL st_denied: got %0b want 0", a_ready); end
        tick;
        tests++; if (DstReg !== 4'd7 || DstData !== 16'h1234 || WriteReg !== 1'b1) begin
            fails++; $display("FAIL st_forced_write: got wr%0b r%0d %h want wr1 r7 1234", WriteReg, DstReg, DstData); end
        tests++; if (forced_b !== 1'b1) begin fails++; $display("FAIL st_forced: got %0b want 1", forced_b); end
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL st_resume: got %0b want 1", a_ready); end
        a_data = 16'h00AA;
        tick;
        tests++; if (DstReg !== 4'd1 || DstData !== 16'h00AA || forced_b !== 1'b0) begin
            fails++; $display("FAIL st_after: got r%0d %h f%0b want r1 00aa f0", DstReg, DstData, forced_b); end
        a_valid = 1'b0;
        tick;
    endtask

    task automatic test_fifo_full;
        a_valid = 1'b1; a_reg = 4'd2; a_data = 16'h2222;
        b_valid = 1'b1; b_reg = 4'd3; b_data = 16'h0333;
        tick;
        b_reg = 4'd4; b_data = 16'h0444;
        tick;
        tests++; if (b_count !== 2'd2) begin fails++; $display("FAIL full_count: got %0d want 2", b_count); end
        tests++; if (b_ready !== 1'b0) begin fails++; $display("FAIL full_bready: got %0b want 0", b_ready); end
        b_reg = 4'd5; b_data = 16'h0555;
        tick;
        tests++; if (b_count !== 2'd2) begin fails++; $display("FAIL full_reject: got %0d want 2", b_count); end
        tests++; if (DstReg !== 4'd2 || WriteReg !== 1'b1) begin fails++; $display("FAIL full_agrant: got r%0d want r2", DstReg); end
`ifdef REGWR_PENDING_MASK_EN
        tests++; if (pending_mask !== 16'h0018) begin fails++; $display("FAIL full_mask: got %h want 0018", pending_mask); end
`endif
        a_valid = 1'b0; b_valid = 1'b0;
        tick;
        tests++; if (DstReg !== 4'd3 || DstData !== 16'h0333) begin fails++; $display("FAIL full_pop1: got r%0d %h want r3 0333", DstReg, DstData); end
        tests++; if (b_count !== 2'd1 || b_ready !== 1'b1) begin fails++; $display("FAIL full_pop1_state: got c%0d rdy%0b want c1 rdy1", b_count, b_ready); end
        tick;
        tests++; if (DstReg !== 4'd4 || DstData !== 16'h0444 || b_count !== 2'd0) begin
            fails++; $display("FAIL full_pop2: got r%0d %h c%0d want r4 0444 c0", DstReg, DstData, b_count); end
        tick;
        tests++; if (WriteReg !== 1'b0) begin fails++; $display("FAIL full_no3rd: got %0b want 0", WriteReg); end
    endtask

    task automatic test_r0;
        a_valid = 1'b1; a_reg = 4'd0; a_data = 16'hFFFF;
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL r0_aready: got %0b want 1", a_ready); end
        tick;
        a_valid = 1'b0;
        tests++; if (WriteReg !== 1'b0) begin fails++; $display("FAIL r0_a_wr: got %0b want 0", WriteReg); end
        b_valid = 1'b1; b_reg = 4'd0; b_data = 16'hDEAD;
        tick;
        b_valid = 1'b0;
        tests++; if (b_count !== 2'd1) begin fails++; $display("FAIL r0_push: got %0d want 1", b_count); end
`ifdef REGWR_PENDING_MASK_EN
        tests++; if (pending_mask !== 16'h0000) begin fails++; $display("FAIL r0_mask: got %h want 0000", pending_mask); end
`endif
        tick;
        tests++; if (b_count !== 2'd0 || WriteReg !== 1'b0) begin
            fails++; $display("FAIL r0_b_pop: got c%0d wr%0b want c0 wr0", b_count, WriteReg); end
    endtask

    task automatic test_back_to_back;
        a_valid = 1'b0;
        b_valid = 1'b1; b_reg = 4'd9; b_data = 16'h0909;
        tick;
        b_reg = 4'd10; b_data = 16'h0A0A;
        tick;
        b_valid = 1'b0;
        tests++; if (b_count !== 2'd1) begin fails++; $display("FAIL bb_count: got %0d want 1", b_count); end
        tests++; if (DstReg !== 4'd9 || DstData !== 16'h0909 || WriteReg !== 1'b1) begin
            fails++; $display("FAIL bb_first: got r%0d %h want r9 0909", DstReg, DstData); end
        tick;
        tests++; if (DstReg !== 4'd10 || DstData !== 16'h0A0A || b_count !== 2'd0) begin
            fails++; $display("FAIL bb_second: got r%0d %h c%0d want r10 0a0a c0", DstReg, DstData, b_count); end
        tick;
    endtask

    task automatic test_reset_mid;
        a_valid = 1'b1; a_reg = 4'd6; a_data = 16'h6666;
        b_valid = 1'b1; b_reg = 4'd3; b_data = 16'h3333;
        tick;
        b_reg = 4'd7; b_data = 16'h7777;
        tick;
        b_valid = 1'b0;
        tests++; if (b_count !== 2'd2) begin fails++; $display("FAIL rm_count: got %0d want 2", b_count); end
`ifdef REGWR_PENDING_MASK_EN
        tests++; if (pending_mask !== 16'h0088) begin fails++; $display("FAIL rm_mask: got %h want 0088", pending_mask); end
`endif
        rst = 1'b1; a_valid = 1'b0;
        tick;
        rst = 1'b0;
        tests++; if (b_count !== 2'd0 || WriteReg !== 1'b0 || DstReg !== 4'd0) begin
            fails++; $display("FAIL rm_cleared: got c%0d wr%0b r%0d want c0 wr0 r0", b_count, WriteReg, DstReg); end
`ifdef REGWR_PENDING_MASK_EN
        tests++; if (pending_mask !== 16'h0000) begin fails++; $display("FAIL rm_mask_clr: got %h want 0000", pending_mask); end
`endif
        for (int k = 0; k < 3; k++) begin
            tick;
            tests++; if (WriteReg !== 1'b0) begin fails++; $display("FAIL rm_nowrite%0d: got %0b want 0", k, WriteReg); end
        end
    endtask

    initial begin
        test_reset;
        test_a_only;
        test_starvation;
        test_fifo_full;
        test_r0;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
